// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, R-type func codes
// and ALU operation codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLLV = 6'b000100;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLLV = 3'b111;

endpackage

// File: rtl/mc_ctrl_r_decode.sv
// Combinational R-type decoder: maps op/func to an ALU operation code and flags
// unsupported encodings. Illegal words decode to ALU_AND (000).
module r_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [2:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_AND;
    legal  = 1'b0;
    if (op == OP_RTYPE) begin
      legal = 1'b1;
      case (func)
        FN_ADD:  alu_op = ALU_ADD;
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_XOR:  alu_op = ALU_XOR;
        FN_NOR:  alu_op = ALU_NOR;
        FN_SLTU: alu_op = ALU_SLTU;
        FN_SLLV: alu_op = ALU_SLLV;
        default: legal  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/WB sequencing of R-type instructions
// with halt handling, sticky illegal flag and a retired-instruction counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  output logic             if_req,
  input  logic             if_ack,
  input  logic [31:0]      instr,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic             ab_load,
  output logic [2:0]       alu_op,
  output logic             res_load,
  output logic             reg_we,
  output logic             pc_inc,
  input  logic             zf_in,
  input  logic             of_in,
  output logic             zf,
  output logic             of,
  output logic             illegal,
  input  logic             halt_req,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  state_t      state, state_nx;
  logic [31:0] ir;
  logic        started;
  logic [2:0]  dec_alu_op;
  logic        dec_legal;

  r_decode u_r_decode (
    .op     (ir[31:26]),
    .func   (ir[5:0]),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  // started keeps if_req low while Rst is held, so the first fetch follows its release
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state   <= ST_FETCH;
      started <= 1'b0;
      ir      <= '0;
      zf      <= 1'b0;
      of      <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
      if (if_req && if_ack) ir <= instr;
      if (res_load) begin
        zf <= zf_in;
        of <= of_in;
      end
      if (pc_inc) begin
        retired <= retired + CNT_W'(1);
        if (!dec_legal) illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    if_req   = 1'b0;
    ab_load  = 1'b0;
    res_load = 1'b0;
    reg_we   = 1'b0;
    pc_inc   = 1'b0;
    alu_op   = ALU_AND;
    case (state)
      ST_FETCH: begin
        if_req = started;
        if (started && if_ack) state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        ab_load  = 1'b1;
        alu_op   = dec_alu_op;
        state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        res_load = 1'b1;
        alu_op   = dec_alu_op;
        state_nx = ST_WB;
      end
      ST_WB: begin
        pc_inc   = 1'b1;
        reg_we   = dec_legal && (ir[15:11] != 5'd0);
        alu_op   = dec_alu_op;
        state_nx = halt_req ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        if (!halt_req) state_nx = ST_FETCH;
      end
      default: state_nx = ST_FETCH;
    endcase
  end

  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign halted = (state == ST_HALT);
  assign busy   = (state != ST_HALT);

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: fixed instruction table, hand-written reset/halt/wrap
// sequences and a randomized instruction stream against a transaction-level model.
module tb_mc_ctrl;

  localparam int CNT_W = 4;
  localparam int MASK  = (1 << CNT_W) - 1;

  logic             Clk;
  logic             Rst;
  logic             if_req;
  logic             if_ack;
  logic [31:0]      instr;
  logic [4:0]       rs, rt, rd;
  logic             ab_load;
  logic [2:0]       alu_op;
  logic             res_load, reg_we, pc_inc;
  logic             zf_in, of_in, zf, of, illegal;
  logic             halt_req, halted, busy;
  logic [CNT_W-1:0] retired;

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .if_req(if_req), .if_ack(if_ack), .instr(instr),
    .rs(rs), .rt(rt), .rd(rd), .ab_load(ab_load), .alu_op(alu_op),
    .res_load(res_load), .reg_we(reg_we), .pc_inc(pc_inc),
    .zf_in(zf_in), .of_in(of_in), .zf(zf), .of(of), .illegal(illegal),
    .halt_req(halt_req), .halted(halted), .busy(busy), .retired(retired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int   m_retired = 0;
  logic m_illegal = 1'b0;

  logic [5:0] fn_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04};
  logic [2:0] op_tab [8] = '{3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  typedef struct {
    logic [31:0] w;
    logic [2:0]  alu;
    logic        legal;
    logic        we;
  } vec_t;

  vec_t tab [11];

  function automatic void ref_decode(input logic [31:0] w, output logic [2:0] a,
                                     output logic lg);
    a  = 3'd0;
    lg = 1'b0;
    if (w[31:26] == 6'd0) begin
      for (int i = 0; i < 8; i++) begin
        if (w[5:0] == fn_tab[i]) begin
          a  = op_tab[i];
          lg = 1'b1;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_strb(input string name, input logic [4:0] exp);
    chk(name, 32'({if_req, ab_load, res_load, reg_we, pc_inc}), 32'(exp));
  endtask

  task automatic do_reset();
    Rst = 1'b0; if_ack = 1'b1; halt_req = 1'b0; instr = $urandom;
    @(negedge Clk);
    chk_strb("rst_strobes", 5'b00000);
    chk("rst_alu", 32'(alu_op), 32'd0);
    chk("rst_regs", 32'({rs, rt, rd}), 32'd0);
    chk("rst_flags", 32'({zf, of, illegal, halted, busy}), 32'b00001);
    chk("rst_retired", 32'(retired), 32'd0);
    Rst = 1'b1; if_ack = 1'b0;
    @(negedge Clk);
    m_retired = 0;
    m_illegal = 1'b0;
  endtask

  // Runs one instruction from the FETCH cycle through WB (and optional HALT).
  task automatic do_instr(input logic [31:0] w, input logic [2:0] ea, input logic el,
                          input logic ewe, input int dly, input int hcyc);
    logic z, o;
    z = 1'($urandom);
    o = 1'($urandom);
    for (int i = 0; i < dly; i++) begin
      chk_strb("fetch_wait", 5'b10000);
      chk("fetch_wait_alu", 32'(alu_op), 32'd0);
      if_ack = 1'b0; instr = $urandom;
      @(negedge Clk);
    end
    chk_strb("fetch", 5'b10000);
    chk("fetch_busy", 32'({halted, busy}), 32'b01);
    if_ack = 1'b1; instr = w;
    @(negedge Clk);
    if_ack = 1'($urandom); instr = $urandom;
    chk_strb("decode", 5'b01000);
    chk("decode_alu", 32'(alu_op), 32'(ea));
    chk("decode_regs", 32'({rs, rt, rd}), 32'(w[25:11]));
    zf_in = z; of_in = o;
    @(negedge Clk);
    chk_strb("exec", 5'b00100);
    chk("exec_alu", 32'(alu_op), 32'(ea));
    @(negedge Clk);
    zf_in = 1'($urandom); of_in = 1'($urandom); if_ack = 1'b0;
    chk_strb("wb", {3'b000, ewe, 1'b1});
    chk("wb_alu", 32'(alu_op), 32'(ea));
    chk("wb_flags", 32'({zf, of}), 32'({z, o}));
    chk("wb_regs", 32'({rs, rt, rd}), 32'(w[25:11]));
    halt_req = (hcyc > 0);
    @(negedge Clk);
    m_retired = (m_retired + 1) & MASK;
    m_illegal = m_illegal | !el;
    chk("retired", 32'(retired), 32'(m_retired));
    chk("illegal", 32'(illegal), 32'(m_illegal));
    for (int i = 0; i < hcyc; i++) begin
      chk("halt_state", 32'({halted, busy}), 32'b10);
      chk_strb("halt_strobes", 5'b00000);
      chk("halt_alu", 32'(alu_op), 32'd0);
      halt_req = (i < hcyc - 1);
      if_ack = 1'($urandom);
      @(negedge Clk);
    end
    halt_req = 1'b0;
    if_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [2:0]  a;
    logic        lg;
    int          k;

    tab[0]  = '{32'h00221820, 3'b100, 1'b1, 1'b1};  // add rd=3
    tab[1]  = '{32'h08000000, 3'b000, 1'b0, 1'b0};  // op != 0
    tab[2]  = '{32'h00221822, 3'b101, 1'b1, 1'b1};  // sub
    tab[3]  = '{32'h00221824, 3'b000, 1'b1, 1'b1};  // and
    tab[4]  = '{32'h00221825, 3'b001, 1'b1, 1'b1};  // or
    tab[5]  = '{32'h00221826, 3'b010, 1'b1, 1'b1};  // xor
    tab[6]  = '{32'h00221827, 3'b011, 1'b1, 1'b1};  // nor
    tab[7]  = '{32'h0022182B, 3'b110, 1'b1, 1'b1};  // sltu
    tab[8]  = '{32'h00221804, 3'b111, 1'b1, 1'b1};  // sllv
    tab[9]  = '{32'h00220022, 3'b101, 1'b1, 1'b0};  // sub rd=0
    tab[10] = '{32'h00221821, 3'b000, 1'b0, 1'b0};  // unlisted func

    Rst = 1'b0; if_ack = 1'b0; instr = '0; zf_in = 1'b0; of_in = 1'b0; halt_req = 1'b0;
    @(negedge Clk);
    do_reset();

    // delayed acknowledge
    do_instr(32'h00221820, 3'b100, 1'b1, 1'b1, 5, 0);
    chk("late_ack_retired", 32'(retired), 32'd1);

    // table, starting from a fresh reset with immediate ack; one entry halts
    do_reset();
    for (int i = 0; i < 11; i++)
      do_instr(tab[i].w, tab[i].alu, tab[i].legal, tab[i].we, (i % 3 == 2) ? 1 : 0,
               (i == 4) ? 2 : 0);

    // reset during EXEC abandons the instruction
    do_reset();
    do_instr(32'h08000000, 3'b000, 1'b0, 1'b0, 0, 0);
    if_ack = 1'b1; instr = 32'h00221820;
    @(negedge Clk);
    if_ack = 1'b0;
    @(negedge Clk);
    chk_strb("abort_exec", 5'b00100);
    Rst = 1'b0;
    @(negedge Clk);
    chk_strb("abort_strobes", 5'b00000);
    chk("abort_flags", 32'({zf, of, illegal, halted}), 32'd0);
    chk("abort_retired", 32'(retired), 32'd0);
    chk("abort_regs", 32'({rs, rt, rd}), 32'd0);
    chk("abort_alu", 32'(alu_op), 32'd0);
    Rst = 1'b1;
    @(negedge Clk);
    m_retired = 0;
    m_illegal = 1'b0;
    chk_strb("abort_refetch", 5'b10000);

    // counter wrap from all-ones
    for (int i = 0; i < MASK; i++)
      do_instr(32'h00221820, 3'b100, 1'b1, 1'b1, 0, 0);
    chk("wrap_full", 32'(retired), 32'(MASK));
    do_instr(32'h00221822, 3'b101, 1'b1, 1'b1, 0, 0);
    chk("wrap_zero", 32'(retired), 32'd0);

    // randomized stream against the model
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      k = $urandom_range(0, 3);
      if (k < 2) begin
        w[31:26] = 6'd0;
        w[5:0]   = fn_tab[$urandom_range(0, 7)];
      end else if (k == 2) begin
        w[31:26] = 6'd0;
      end
      if ($urandom_range(0, 5) == 0) w[15:11] = 5'd0;
      ref_decode(w, a, lg);
      do_instr(w, a, lg, lg && (w[15:11] != 5'd0), $urandom_range(0, 3),
               ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Rst  input  1  reset is synchronous and active-low; the block resets on a rising Clk edge while Rst=0.
REQ-004 if_req  output  1  instruction fetch request to the instruction fetch unit.
REQ-005 if_ack  input  1  fetch done; instr is valid in the same cycle.
REQ-006 instr  input  32  fetched R-type word: op[31:26], rs[25:21], rt[20:16], rd[15:11], func[5:0].
REQ-007 rs, rt, rd  output  5 each  register addresses from the latched IR.
REQ-008 ab_load  output  1  register-file operand latch strobe.
REQ-009 alu_op  output  3  ALU operation code.
REQ-010 res_load  output  1  ALU result/flag latch strobe.
REQ-011 reg_we  output  1  register-file write enable.
REQ-012 pc_inc  output  1  one-cycle PC advance pulse.
REQ-013 zf_in, of_in  input  1 each  ALU zero/overflow flags.
REQ-014 zf, of  output  1 each  flags registered at res_load.
REQ-015 illegal  output  1  sticky flag: at least one unsupported instruction was retired.
REQ-016 halt_req  input  1  stop request, sampled only in WB.
REQ-017 halted  output  1  high while in HALT.
REQ-018 busy  output  1  high in every state except HALT.
REQ-019 retired  output  CNT_W  count of instructions retired.

Function
REQ-020 FSM states FETCH, DECODE, EXEC, WB, HALT; exactly one state per cycle.
REQ-021 FETCH: if_req=1; on if_ack=1 latch instr into IR and go to DECODE; otherwise stay in FETCH with no timeout.
REQ-022 DECODE: ab_load=1 for one cycle; go to EXEC.
REQ-023 EXEC: alu_op driven from IR; res_load=1; latch zf_in/of_in into zf/of; go to WB.
REQ-024 alu_op SHALL be valid from DECODE through WB, and SHALL be 000 in FETCH and HALT.
REQ-025 Decode with op=000000: func 100000->100, 100010->101, 100100->000, 100101->001, 100110->010, 100111->011, 101011->110, 000100->111.
REQ-026 Any op!=000000 or unlisted func is illegal: alu_op=000, reg_we stays 0, illegal set in WB.
REQ-027 WB: reg_we=1 only if the instruction is legal and rd!=0; pc_inc=1; retired increments by 1 with wrap to 0 from all-ones.
REQ-028 WB exit: halt_req=1 goes to HALT; otherwise goes to FETCH.
REQ-029 HALT: all strobes 0; stays in HALT while halt_req=1; on halt_req=0 goes to FETCH on the next edge.
REQ-030 An if_ack seen outside FETCH SHALL be ignored.
REQ-031 Minimum latency is 4 cycles per instruction (FETCH with immediate ack, DECODE, EXEC, WB).
REQ-032 All strobes (if_req, ab_load, res_load, reg_we, pc_inc) are Moore outputs decoded from state; at most one of ab_load, res_load, reg_we is high in any cycle.

Reset
REQ-033 Rst=0 forces state FETCH, IR=0, zf=of=illegal=0, retired=0, and all strobes 0 in the following cycle.
REQ-034 Rst has priority over every other input, and an instruction in flight when Rst falls is abandoned with no reg_we or pc_inc.
REQ-035 The first if_req is asserted in the first cycle after Rst returns to 1.

Structure
REQ-036 A shared package holds the state encoding (3-bit), the 8 func constants, and the 8 alu_op constants.
REQ-037 The combinational func-to-alu_op decoder is a sub-module named r_decode (inputs op, func; outputs alu_op, legal).
REQ-038 The block contains no datapath storage except IR, zf/of, illegal, and retired.

Verification
REQ-039 Reset, then instr=0x00221820 (add rd=3), if_ack immediate -> alu_op=100, and reg_we+pc_inc in cycle 4; retired=1.
REQ-040 if_ack held low 5 cycles -> FSM stays in FETCH with if_req=1 throughout; then ack -> normal completion, retired=1.
REQ-041 instr=0x08000000 (op!=0) -> no reg_we, pc_inc=1, illegal=1 and stays 1 on the following legal instruction.
REQ-042 Legal sub with rd=0 -> reg_we=0, pc_inc=1, retired increments.
REQ-043 halt_req=1 during WB -> halted=1, busy=0, no if_req; release -> FETCH on the next cycle.
REQ-044 Rst=0 during EXEC -> no reg_we or pc_inc, all outputs return to reset values; retired preset to all-ones then 1 instruction -> retired=0.
